// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master arbiter slice.
// Build option: SPI_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package spi_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned SEL_W_DEF       = 2;
  localparam int unsigned XFER_CYCLES_DEF = 9;

  function automatic int unsigned cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_w(XFER_CYCLES_DEF);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest-index-wins
// when SPI_ARB_FIXED_PRIO_EN is defined (ptr port is then absent).
module spi_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifdef SPI_ARB_FIXED_PRIO_EN
`else
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan downward so the lowest active index is the last one written.
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[IDX_W'(i - 1)]) begin
        onehot                 = '0;
        onehot[IDX_W'(i - 1)]  = 1'b1;
        idx                    = IDX_W'(i - 1);
        any                    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic [IDX_W-1:0] k;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[k]) begin
        onehot[k] = 1'b1;
        idx       = k;
        any       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI Master between NUM_REQ requesters; owns all Master controls.
// Build option: SPI_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned MAX_SEL     = 2,
  parameter int unsigned XFER_CYCLES = XFER_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      err,
  output logic                      busy,
  output logic                      start,
  output logic [SEL_W-1:0]          slaveSelect,
  output logic [DATA_W-1:0]         masterDataToSend,
  input  logic [DATA_W-1:0]         masterDataReceived
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = cnt_w(XFER_CYCLES);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pick_oh, owner;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any, pick_ill, ill_q;
  logic [SEL_W-1:0]   pick_sel, sel_q;
  logic [DATA_W-1:0]  pick_data, data_q, rsp_q;
  logic [CNT_W-1:0]   cnt;

`ifdef SPI_ARB_FIXED_PRIO_EN
  spi_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );
`else
  logic [IDX_W-1:0] ptr;

  spi_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == IDLE && pick_any) begin
      ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  assign pick_sel  = req_sel[pick_idx*SEL_W +: SEL_W];
  assign pick_data = req_data[pick_idx*DATA_W +: DATA_W];
  assign pick_ill  = (pick_sel > SEL_W'(MAX_SEL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = pick_ill ? DONE : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // gnt is combinational in IDLE, so it is masked while reset is asserted.
  always_comb begin
    gnt   = '0;
    done  = '0;
    err   = 1'b0;
    busy  = 1'b0;
    start = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && pick_any) begin
          gnt  = pick_oh;
          busy = 1'b1;
        end
      end
      LAUNCH: begin
        start = 1'b1;
        busy  = 1'b1;
      end
      WAIT: busy = 1'b1;
      DONE: begin
        done = owner;
        err  = ill_q;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // rsp_data is loaded on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= '0;
      sel_q  <= '0;
      data_q <= '0;
      ill_q  <= 1'b0;
      rsp_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner  <= pick_oh;
            sel_q  <= pick_sel;
            data_q <= pick_data;
            ill_q  <= pick_ill;
            if (pick_ill) rsp_q <= '0;
          end
        end
        LAUNCH: cnt <= CNT_W'(XFER_CYCLES - 1);
        WAIT: begin
          if (cnt == '0) rsp_q <= masterDataReceived;
          else           cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign slaveSelect      = sel_q;
  assign masterDataToSend = data_q;
  assign rsp_data         = rsp_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter with a simple SPI Master model.
// Expectations follow SPI_ARB_FIXED_PRIO_EN when it is defined.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_sel;
  logic [31:0] req_data;
  logic [3:0]  gnt, done;
  logic [7:0]  rsp_data;
  logic        err, busy, start;
  logic [1:0]  slaveSelect;
  logic [7:0]  masterDataToSend;
  logic [7:0]  mdr = 8'hEE;
  logic [7:0]  rx = 8'h00;
  logic        armed = 1'b0;
  int unsigned m_cnt = 0;

  int tests = 0;
  int fails = 0;

  spi_master_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .SEL_W(2), .MAX_SEL(2), .XFER_CYCLES(9)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .req_sel            (req_sel),
    .req_data           (req_data),
    .gnt                (gnt),
    .done               (done),
    .rsp_data           (rsp_data),
    .err                (err),
    .busy               (busy),
    .start              (start),
    .slaveSelect        (slaveSelect),
    .masterDataToSend   (masterDataToSend),
    .masterDataReceived (mdr)
  );

  always #5 clk = ~clk;

  // Master model: received byte is valid only in the 9th cycle after the start cycle.
  always @(negedge clk) begin
    if (reset) begin
      armed = 1'b0;
      m_cnt = 0;
    end else if (start) begin
      m_cnt = 9;
      armed = 1'b1;
    end else if (armed) begin
      if (m_cnt == 0) armed = 1'b0;
      else            m_cnt--;
    end
    mdr = (armed && m_cnt == 0) ? rx : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a gnt cycle; returns in the done cycle.
  task automatic run_xfer(input string tag, input int unsigned idx, input logic [1:0] esel,
                          input logic [7:0] edata, input logic [7:0] ersp, input logic eerr);
    logic [3:0]  oh;
    int unsigned lat, starts;
    bit          got;
    oh     = 4'b0001 << idx;
    lat    = 0;
    starts = 0;
    got    = 1'b0;
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    check({tag, "_busy_gnt"}, 32'(busy), 32'd1);
    while (!got && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (start) starts++;
      if (done != 4'b0000) got = 1'b1;
      else if (!eerr) begin
        check({tag, "_sel"}, 32'(slaveSelect), 32'(esel));
        check({tag, "_txd"}, 32'(masterDataToSend), 32'(edata));
      end
      if (lat == 1 && !eerr) check({tag, "_start_launch"}, 32'(start), 32'd1);
    end
    check({tag, "_done"}, 32'(done), 32'(oh));
    check({tag, "_lat"}, lat, eerr ? 32'd1 : 32'd11);
    check({tag, "_rsp"}, 32'(rsp_data), 32'(ersp));
    check({tag, "_err"}, 32'(err), 32'(eerr));
    check({tag, "_starts"}, starts, eerr ? 32'd0 : 32'd1);
  endtask

  logic [7:0]  fair_data [4] = '{8'h3C, 8'h55, 8'h5F, 8'hA5};
`ifdef SPI_ARB_FIXED_PRIO_EN
  int unsigned exp6 [3] = '{1, 1, 1};
`else
  int unsigned exp6 [3] = '{3, 1, 3};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_sel  = '0;
    req_data = '0;

    // Reset state, including gnt masked while reset is held.
    @(negedge clk); #1;
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_sel",   32'(slaveSelect), 32'd0);
    check("rst_txd",   32'(masterDataToSend), 32'd0);
    check("rst_rsp",   32'(rsp_data), 32'd0);
    req = 4'b1111; #1;
    check("rst_gnt_req", 32'(gnt), 32'd0);
    check("rst_busy_req", 32'(busy), 32'd0);
    req = 4'b0000;
    @(negedge clk); reset = 1'b0;

    // 1: single transfer
    @(negedge clk);
    req_sel = 8'b00_00_00_01; req_data = 32'h0000_0053; req = 4'b0001; rx = 8'h09; #1;
    run_xfer("t1", 0, 2'd1, 8'h53, 8'h09, 1'b0);
    req = 4'b0000;
    @(negedge clk); #1;
    check("t1_idle_done", 32'(done), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_rsp_hold", 32'(rsp_data), 32'h09);

    // 2: fairness from a fresh pointer
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    req_sel = 8'b01_01_01_01; req_data = 32'hA55F_553C; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      rx = fair_data[i % 4] ^ 8'hFF; #1;
      run_xfer($sformatf("t2_%0d", i), i % 4, 2'd1, fair_data[i % 4], fair_data[i % 4] ^ 8'hFF, 1'b0);
    end

    // 3: pointer wrap (pointer is 1 here)
    req = 4'b1000; req_sel[7:6] = 2'd2; req_data[31:24] = 8'h81;
    @(negedge clk); rx = 8'h18; #1;
    run_xfer("t3a", 3, 2'd2, 8'h81, 8'h18, 1'b0);
    req = 4'b1001; req_sel[1:0] = 2'd0; req_data[7:0] = 8'h42;
    @(negedge clk); rx = 8'h24; #1;
    run_xfer("t3b", 0, 2'd0, 8'h42, 8'h24, 1'b0);
    @(negedge clk); rx = 8'h18; #1;
    run_xfer("t3c", 3, 2'd2, 8'h81, 8'h18, 1'b0);
    req = 4'b0000;

    // 4: illegal select
    @(negedge clk);
    req_sel[5:4] = 2'd3; req_data[23:16] = 8'h99; req = 4'b0100; #1;
    run_xfer("t4", 2, 2'd3, 8'h99, 8'h00, 1'b1);
    req = 4'b0000;
    @(negedge clk); #1;
    check("t4_after_err", 32'(err), 32'd0);
    check("t4_after_done", 32'(done), 32'd0);
    check("t4_after_busy", 32'(busy), 32'd0);

    // 5: reset while WAIT counter is 4
    @(negedge clk);
    req_sel[3:2] = 2'd2; req_data[15:8] = 8'h77; req = 4'b0010; rx = 8'h66; #1;
    check("t5_gnt", 32'(gnt), 32'b0010);
    @(negedge clk); req = 4'b0000; #1;
    check("t5_start", 32'(start), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1; req = 4'b0010; #1;
    check("t5_rst_start", 32'(start), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_sel", 32'(slaveSelect), 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      check("t5_held_done", 32'(done), 32'd0);
      check("t5_held_start", 32'(start), 32'd0);
    end
    reset = 1'b0; req_sel[3:2] = 2'd0; req_data[15:8] = 8'hFF; rx = 8'h5A; #1;
    run_xfer("t5b", 1, 2'd0, 8'hFF, 8'h5A, 1'b0);
    req = 4'b0000;

    // 6: req 1 and 3 held (pointer is 2 here)
    @(negedge clk);
    req_sel[3:2] = 2'd1; req_sel[7:6] = 2'd1;
    req_data[15:8] = 8'h11; req_data[31:24] = 8'h33; req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      rx = 8'hC0 | 8'(exp6[i]); #1;
      run_xfer($sformatf("t6_%0d", i), exp6[i], 2'd1,
               (exp6[i] == 1) ? 8'h11 : 8'h33, 8'hC0 | 8'(exp6[i]), 1'b0);
    end
    req = 4'b0000;
    @(negedge clk); #1;
    check("t6_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
